id_ex_alu_ctrl: RTL and testbench



---
 rtl/id_ex_alu_ctrl_if.sv | 48 ++++
 rtl/id_ex_alu_ctrl.sv | 131 +++++++++++++
 tb/tb_id_ex_alu_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_alu_ctrl_if.sv
// ID -> EX bundle for the id_ex_alu_ctrl pipeline register.
//   master : ID / hazard-unit side (drives stall, flush and the id_* fields,
//            observes the registered ex_* outputs)
//   slave  : the pipeline register itself
interface id_ex_alu_ctrl_if #(
  parameter int WIDTH = 32
);
  // hazard control
  logic             stall;
  logic             flush;
  // ID-stage decoded fields
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [5:0]       id_funct;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [15:0]      id_imm;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  // EX-stage registered outputs
  logic             ex_valid;
  logic [1:0]       ex_signal;
  logic             ex_inv;
  logic             ex_cin;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [WIDTH-1:0] ex_store_data;
  logic [4:0]       ex_dst;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_branch;
  logic             ex_illegal;

  modport master (
    output stall, flush, id_valid, id_opcode, id_funct,
           id_rs_data, id_rt_data, id_imm, id_rt, id_rd,
    input  ex_valid, ex_signal, ex_inv, ex_cin, ex_a, ex_b, ex_store_data,
           ex_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );

  modport slave (
    input  stall, flush, id_valid, id_opcode, id_funct,
           id_rs_data, id_rt_data, id_imm, id_rt, id_rd,
    output ex_valid, ex_signal, ex_inv, ex_cin, ex_a, ex_b, ex_store_data,
           ex_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal
  );
endinterface

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline register with ALU-control decode.
// Decodes opcode/funct into the per-slice ALU controls (signal, inv, cin)
// plus memory/write-back flags, and registers them with the operands.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, loads a bubble
//   bus  : id_ex_alu_ctrl_if.slave -- stall/flush, id_* inputs, ex_* outputs
// Edge priority: rst > flush > stall (hold) > !id_valid (bubble) > load.
module id_ex_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_alu_ctrl_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] SIG_AND  = 2'b00;
  localparam logic [1:0] SIG_OR   = 2'b01;
  localparam logic [1:0] SIG_SUM  = 2'b10;
  localparam logic [1:0] SIG_LESS = 2'b11;

  // All-zero value of this struct is the bubble.
  typedef struct packed {
    logic             valid;
    logic [1:0]       signal;
    logic             inv;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] store_data;
    logic [4:0]       dst;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             illegal;
  } ex_t;

  ex_t              dec;
  ex_t              ex_d, ex_q;
  logic             legal;
  logic [WIDTH-1:0] imm_sx;

  // ---------------- decode (ID stage, combinational) ----------------
  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    imm_sx = {{(WIDTH-16){bus.id_imm[15]}}, bus.id_imm};
    dec.valid = 1'b1;
    dec.a     = bus.id_rs_data;
    unique case (bus.id_opcode)
      OP_RTYPE: begin
        dec.b         = bus.id_rt_data;
        dec.dst       = bus.id_rd;
        dec.reg_write = 1'b1;
        unique case (bus.id_funct)
          FN_AND:  dec.signal = SIG_AND;
          FN_OR:   dec.signal = SIG_OR;
          FN_ADD:  dec.signal = SIG_SUM;
          // subtract = A + ~B + 1 across the slice chain
          FN_SUB:  begin dec.signal = SIG_SUM;  dec.inv = 1'b1; dec.cin = 1'b1; end
          FN_SLT:  begin dec.signal = SIG_LESS; dec.inv = 1'b1; dec.cin = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec.signal    = SIG_SUM;
        dec.b         = imm_sx;
        dec.dst       = bus.id_rt;
        dec.reg_write = (bus.id_opcode != OP_SW);
        dec.mem_read  = (bus.id_opcode == OP_LW);
        dec.mem_write = (bus.id_opcode == OP_SW);
        if (bus.id_opcode == OP_SW) dec.store_data = bus.id_rt_data;
      end
      OP_BEQ: begin
        // compare by subtraction; zero detect happens in EX
        dec.signal = SIG_SUM;
        dec.inv    = 1'b1;
        dec.cin    = 1'b1;
        dec.b      = bus.id_rt_data;
        dec.branch = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // unsupported encodings become a flagged bubble
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    ex_d = ex_q;
    if (bus.flush)         ex_d = '0;
    else if (bus.stall)    ex_d = ex_q;
    else if (!bus.id_valid) ex_d = '0;
    else                   ex_d = dec;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_signal     = ex_q.signal;
  assign bus.ex_inv        = ex_q.inv;
  assign bus.ex_cin        = ex_q.cin;
  assign bus.ex_a          = ex_q.a;
  assign bus.ex_b          = ex_q.b;
  assign bus.ex_store_data = ex_q.store_data;
  assign bus.ex_dst        = ex_q.dst;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Self-checking bench for id_ex_alu_ctrl: directed scenarios followed by
// randomized traffic, compared every cycle against an instruction-level model.
module tb_id_ex_alu_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_alu_ctrl_if #(.WIDTH(W)) bus ();

  id_ex_alu_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef enum int {K_AND, K_OR, K_ADD, K_SUB, K_SLT,
                    K_ADDI, K_LW, K_SW, K_BEQ, K_ILL} kind_e;

  typedef struct {
    logic         valid;
    kind_e        kind;
    logic [1:0]   sig;
    logic         inv, cin;
    logic [W-1:0] a, b, sd;
    logic [4:0]   dst;
    logic         rw, mr, mw, br, ill;
  } exp_t;

  exp_t exp_q;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic exp_t bubble(input logic ill);
    exp_t e;
    e.valid = 0; e.kind = K_ILL; e.sig = 0; e.inv = 0; e.cin = 0;
    e.a = 0; e.b = 0; e.sd = 0; e.dst = 0;
    e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = ill;
    return e;
  endfunction

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h24) return K_AND;
      if (fn == 6'h25) return K_OR;
      if (fn == 6'h20) return K_ADD;
      if (fn == 6'h22) return K_SUB;
      if (fn == 6'h2A) return K_SLT;
      return K_ILL;
    end
    if (op == 6'h08) return K_ADDI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    return K_ILL;
  endfunction

  // Expected EX contents for a valid ID instruction, from per-op properties.
  function automatic exp_t load_model();
    exp_t  e;
    kind_e k = classify(bus.id_opcode, bus.id_funct);
    logic  rtype, immop, subtr;
    if (k == K_ILL) return bubble(1'b1);
    rtype = (k inside {K_AND, K_OR, K_ADD, K_SUB, K_SLT});
    immop = (k inside {K_ADDI, K_LW, K_SW});
    subtr = (k inside {K_SUB, K_SLT, K_BEQ});
    e = bubble(1'b0);
    e.valid = 1; e.kind = k;
    e.sig = (k == K_AND) ? 2'd0 : (k == K_OR) ? 2'd1 : (k == K_SLT) ? 2'd3 : 2'd2;
    e.inv = subtr; e.cin = subtr;
    e.a   = bus.id_rs_data;
    // sign extension as arithmetic: values >= 0x8000 are negative
    if (immop) e.b = bus.id_imm >= 16'h8000 ? W'(bus.id_imm) - W'(32'h10000) : W'(bus.id_imm);
    else       e.b = bus.id_rt_data;
    e.sd  = (k == K_SW) ? bus.id_rt_data : '0;
    e.dst = rtype ? bus.id_rd : immop ? bus.id_rt : 5'd0;
    e.rw  = rtype || k == K_ADDI || k == K_LW;
    e.mr  = (k == K_LW);
    e.mw  = (k == K_SW);
    e.br  = (k == K_BEQ);
    return e;
  endfunction

  // Ripple chain of 1-bit slices driven by the DUT's controls.
  function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] sg, input logic inv, input logic cin);
    logic [W-1:0] r, s;
    logic c, bb, cprev, set;
    c = cin; cprev = 0;
    for (int i = 0; i < W; i++) begin
      bb = b[i] ^ inv;
      s[i] = a[i] ^ bb ^ c;
      cprev = c;
      c = (a[i] & bb) | (a[i] & c) | (bb & c);
      r[i] = (sg == 2'd0) ? (a[i] & bb) : (sg == 2'd1) ? (a[i] | bb) : s[i];
    end
    set = s[W-1] ^ (cprev ^ c);          // overflow-corrected sign
    if (sg == 2'd3) r = {{(W-1){1'b0}}, set};
    return r;
  endfunction

  function automatic logic [W-1:0] semantic(input kind_e k, input logic [W-1:0] a, input logic [W-1:0] b);
    case (k)
      K_AND:        return a & b;
      K_OR:         return a | b;
      K_SUB, K_BEQ: return a - b;
      K_SLT:        return ($signed(a) < $signed(b)) ? 1 : 0;
      default:      return a + b;
    endcase
  endfunction

  task automatic check_all();
    chk("valid", bus.ex_valid,      exp_q.valid);
    chk("signal", bus.ex_signal,    exp_q.sig);
    chk("inv",   bus.ex_inv,        exp_q.inv);
    chk("cin",   bus.ex_cin,        exp_q.cin);
    chk("a",     bus.ex_a,          exp_q.a);
    chk("b",     bus.ex_b,          exp_q.b);
    chk("store", bus.ex_store_data, exp_q.sd);
    chk("dst",   bus.ex_dst,        exp_q.dst);
    chk("rw",    bus.ex_reg_write,  exp_q.rw);
    chk("mr",    bus.ex_mem_read,   exp_q.mr);
    chk("mw",    bus.ex_mem_write,  exp_q.mw);
    chk("br",    bus.ex_branch,     exp_q.br);
    chk("ill",   bus.ex_illegal,    exp_q.ill);
    if (exp_q.valid)
      chk("alu", alu(bus.ex_a, bus.ex_b, bus.ex_signal, bus.ex_inv, bus.ex_cin),
          semantic(exp_q.kind, exp_q.a, exp_q.b));
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    @(posedge clk);
    if (rst || bus.flush)   exp_q = bubble(1'b0);
    else if (bus.stall)     exp_q = exp_q;
    else if (!bus.id_valid) exp_q = bubble(1'b0);
    else                    exp_q = load_model();
    #1;
    check_all();
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input logic [15:0] imm, input logic [4:0] rtn, input logic [4:0] rdn);
    bus.id_valid = v; bus.id_opcode = op; bus.id_funct = fn;
    bus.id_rs_data = rs; bus.id_rt_data = rt; bus.id_imm = imm;
    bus.id_rt = rtn; bus.id_rd = rdn;
  endtask

  initial begin
    logic [5:0] ops [5];
    logic [5:0] fns [5];
    ops = '{6'h08, 6'h23, 6'h2B, 6'h04, 6'h00};
    fns = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
    exp_q = bubble(1'b0);

    // reset with a valid garbage instruction presented
    rst = 1; bus.stall = 0; bus.flush = 0;
    set_id(1, 6'h00, 6'h20, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1234, 5'd3, 5'd7);
    tick(); tick();
    rst = 0;

    // SUB 5 - 7
    set_id(1, 6'h00, 6'h22, 32'd5, 32'd7, 16'h0, 5'd2, 5'd9);
    tick();
    chk("sub_result", alu(bus.ex_a, bus.ex_b, bus.ex_signal, bus.ex_inv, bus.ex_cin), 32'hFFFFFFFE);

    // lw with negative offset
    set_id(1, 6'h23, 6'h00, 32'h100, 32'h0, 16'hFFFC, 5'd4, 5'd0);
    tick();
    chk("sx_b", bus.ex_b, 32'hFFFFFFFC);

    // SLT then 3-cycle stall with changing ID inputs, then stall+flush
    set_id(1, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 16'h0, 5'd1, 5'd10);
    tick();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 6'h00, 6'h24, $urandom, $urandom, 16'h0, 5'd1, 5'd2);
      tick();
      chk("stall_sig", bus.ex_signal, 2'b11);
    end
    bus.flush = 1;
    tick();
    chk("flush_valid", bus.ex_valid, 1'b0);
    bus.stall = 0; bus.flush = 0;

    // illegal opcode, then AND clears it
    set_id(1, 6'h3F, 6'h24, 32'h1, 32'h2, 16'h0, 5'd1, 5'd2);
    tick();
    chk("illegal_flag", bus.ex_illegal, 1'b1);
    set_id(1, 6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd1, 5'd3);
    tick();

    // back-to-back AND, OR, ADD, beq
    set_id(1, 6'h00, 6'h24, 32'h0000FFFF, 32'h00FF00FF, 16'h0, 5'd1, 5'd5); tick();
    set_id(1, 6'h00, 6'h25, 32'h0000FFFF, 32'h00FF00FF, 16'h0, 5'd1, 5'd6); tick();
    set_id(1, 6'h00, 6'h20, 32'h7FFFFFFF, 32'h1,        16'h0, 5'd1, 5'd7); tick();
    set_id(1, 6'h04, 6'h00, 32'h12345678, 32'h12345678, 16'h0010, 5'd8, 5'd0); tick();
    chk("beq_branch", bus.ex_branch, 1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 9);
      logic [5:0] op, fn;
      op = (r < 5) ? 6'h00 : (r < 9) ? ops[r-5] : 6'($urandom);
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      set_id($urandom_range(0, 99) < 85, op, fn, $urandom, $urandom,
             16'($urandom), 5'($urandom), 5'($urandom));
      bus.stall = $urandom_range(0, 99) < 15;
      bus.flush = $urandom_range(0, 99) < 8;
      rst       = $urandom_range(0, 99) < 3;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
